hqb_col_streamer: RTL and testbench

//  Receive end of the H*B column interface of the SOML decoder. Captures the four packed
//  64-bit column words (col0/col1, real/imag) on the finish pulse of the column generator,

---
 rtl/hqb_col_streamer_pkg.sv | 43 ++++
 rtl/hqb_col_streamer_if.sv | 38 +++
 rtl/hqb_col_streamer_bank.sv | 54 +++++
 rtl/hqb_col_streamer.sv | 128 ++++++++++++
 tb/tb_hqb_col_streamer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hqb_col_streamer_pkg.sv
// ============================================================================
// Module  : hqb_col_streamer_pkg
// Brief   : Shared sizes, state codes and element helper for the H*B column streamer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hqb_col_streamer_pkg;

    localparam int DW      = 16;
    localparam int FRAC    = 8;
    localparam int ROWS    = 4;
    localparam int COLS    = 2;
    localparam int SET_LEN = ROWS * COLS;
    localparam int WORD_W  = ROWS * DW;
    localparam int IDX_W   = 3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    typedef struct packed {
        logic [WORD_W-1:0] c0_r;
        logic [WORD_W-1:0] c0_i;
        logic [WORD_W-1:0] c1_r;
        logic [WORD_W-1:0] c1_i;
    } col_set_t;

    // Row 0 sits in the most significant lane of a packed column word.
    function automatic logic [DW-1:0] elem_sel(input logic [WORD_W-1:0] word,
                                               input logic [1:0]        row);
        logic [DW-1:0] e;
        case (row)
            2'd0:    e = word[3*DW +: DW];
            2'd1:    e = word[2*DW +: DW];
            2'd2:    e = word[1*DW +: DW];
            default: e = word[0*DW +: DW];
        endcase
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hqb_col_streamer_if.sv
// ============================================================================
// Module  : hqb_col_streamer_if
// Brief   : Column-set capture inputs and element stream handshake bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface hqb_col_streamer_if;
    import hqb_col_streamer_pkg::*;

    logic              col_valid;
    logic [WORD_W-1:0] col0_r;
    logic [WORD_W-1:0] col0_i;
    logic [WORD_W-1:0] col1_r;
    logic [WORD_W-1:0] col1_i;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_r;
    logic [DW-1:0]     out_i;
    logic              out_col;
    logic [1:0]        out_row;
    logic              out_last;
    logic              busy;
    logic              overrun;

    modport slave (
        input  col_valid, col0_r, col0_i, col1_r, col1_i, out_ready,
        output out_valid, out_r, out_i, out_col, out_row, out_last, busy, overrun
    );

    modport master (
        output col_valid, col0_r, col0_i, col1_r, col1_i, out_ready,
        input  out_valid, out_r, out_i, out_col, out_row, out_last, busy, overrun
    );

endinterface

`default_nettype wire

// File: rtl/hqb_col_streamer_bank.sv
// ============================================================================
// Module  : hqb_col_bank
// Brief   : Four-word column-set register with load enable and element select.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hqb_col_bank
    import hqb_col_streamer_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_load,
    input  wire col_set_t     i_set,
    input  wire logic [2:0]   i_sel,
    output logic [DW-1:0]     o_re,
    output logic [DW-1:0]     o_im,
    output col_set_t          o_set
);

    col_set_t set_q;
    col_set_t set_d;

    always_comb begin
        set_d = set_q;
        if (i_load) begin
            set_d = i_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            set_q <= '0;
        end else begin
            set_q <= set_d;
        end
    end

    // Select bit 2 picks the column, bits 1:0 the row within it.
    always_comb begin
        if (i_sel[2]) begin
            o_re = elem_sel(set_q.c1_r, i_sel[1:0]);
            o_im = elem_sel(set_q.c1_i, i_sel[1:0]);
        end else begin
            o_re = elem_sel(set_q.c0_r, i_sel[1:0]);
            o_im = elem_sel(set_q.c0_i, i_sel[1:0]);
        end
    end

    assign o_set = set_q;

endmodule

`default_nettype wire

// File: rtl/hqb_col_streamer.sv
// ============================================================================
// Module  : hqb_col_streamer
// Brief   : Captures an H*B column set and streams it one complex element per handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hqb_col_streamer
    import hqb_col_streamer_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    hqb_col_streamer_if.slave  bus
);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_full_q, pend_full_d;
    logic             overrun_q, overrun_d;

    logic     act_load, act_src_pend, pend_load;
    logic     xfer, at_last;
    col_set_t in_set, pend_set, act_in;
    col_set_t unused_act_set;
    logic [DW-1:0] act_re, act_im;
    logic [DW-1:0] unused_pend_re, unused_pend_im;

    assign in_set  = {bus.col0_r, bus.col0_i, bus.col1_r, bus.col1_i};
    assign act_in  = act_src_pend ? pend_set : in_set;
    assign xfer    = (state_q == ST_STREAM) && bus.out_ready;
    assign at_last = (idx_q == 3'd7);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_full_d  = pend_full_q;
        overrun_d    = overrun_q;
        act_load     = 1'b0;
        act_src_pend = 1'b0;
        pend_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.col_valid) begin
                    act_load = 1'b1;
                    idx_d    = '0;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    idx_d = idx_q + 3'd1;
                end
                // The slot freed by the final transfer is refilled in the same cycle.
                if (xfer && at_last) begin
                    if (pend_full_q) begin
                        act_load     = 1'b1;
                        act_src_pend = 1'b1;
                        if (bus.col_valid) begin
                            pend_load = 1'b1;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (bus.col_valid) begin
                        act_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.col_valid) begin
                    if (!pend_full_q) begin
                        pend_load   = 1'b1;
                        pend_full_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
        end
    end

    hqb_col_bank u_act_bank (
        .clk    (clk),
        .rst    (rst),
        .i_load (act_load),
        .i_set  (act_in),
        .i_sel  (idx_q),
        .o_re   (act_re),
        .o_im   (act_im),
        .o_set  (unused_act_set)
    );

    hqb_col_bank u_pend_bank (
        .clk    (clk),
        .rst    (rst),
        .i_load (pend_load),
        .i_set  (in_set),
        .i_sel  (idx_q),
        .o_re   (unused_pend_re),
        .o_im   (unused_pend_im),
        .o_set  (pend_set)
    );

    assign bus.out_valid = (state_q == ST_STREAM);
    assign bus.out_r     = act_re;
    assign bus.out_i     = act_im;
    assign bus.out_col   = idx_q[2];
    assign bus.out_row   = idx_q[1:0];
    assign bus.out_last  = (state_q == ST_STREAM) && at_last;
    assign bus.busy      = (state_q == ST_STREAM) || pend_full_q;
    assign bus.overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_hqb_col_streamer.sv
// ============================================================================
// Module  : tb_hqb_col_streamer
// Brief   : Directed self-checking bench for the H*B column streamer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hqb_col_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hqb_col_streamer_if bus ();

    hqb_col_streamer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Set A, B, C column words: col0_r, col0_i, col1_r, col1_i
    logic [63:0] set_w [3][4] = '{
        '{64'h0100_0200_0300_0400, 64'h0001_0002_0003_0004, 64'hFF00_FE00_FD00_FC00, 64'h0},
        '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_0F0F_F0F0},
        '{64'hC0C0_C0C0_C0C0_C0C0, 64'hC0C0_C0C0_C0C0_C0C0, 64'hC0C0_C0C0_C0C0_C0C0, 64'hC0C0_C0C0_C0C0_C0C0}
    };
    logic [15:0] exp_r [3][8] = '{
        '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00},
        '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC},
        '{16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0}
    };
    logic [15:0] exp_i [3][8] = '{
        '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'hDDDD, 16'hEEEE, 16'h0F0F, 16'hF0F0},
        '{16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0, 16'hC0C0}
    };

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic pulse_set(input int s);
        bus.col_valid = 1'b1;
        bus.col0_r    = set_w[s][0];
        bus.col0_i    = set_w[s][1];
        bus.col1_r    = set_w[s][2];
        bus.col1_i    = set_w[s][3];
        @(negedge clk);
        bus.col_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b b=%b o=%b l=%b exp 0 0 0 0", bus.out_valid, bus.busy, bus.overrun, bus.out_last);
        end
        checks++;
        if (bus.out_r !== 16'h0 || bus.out_i !== 16'h0 || bus.out_col !== 1'b0 || bus.out_row !== 2'd0) begin
            errors++;
            $display("FAIL reset_data got r=%h i=%h c=%b row=%0d exp all zero", bus.out_r, bus.out_i, bus.out_col, bus.out_row);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        pulse_set(0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_r !== exp_r[0][k] || bus.out_i !== exp_i[0][k]) begin
                errors++;
                $display("FAIL stream_elem%0d got v=%b %h,%h exp 1 %h,%h", k, bus.out_valid, bus.out_r, bus.out_i, exp_r[0][k], exp_i[0][k]);
            end
            checks++;
            if (bus.out_col !== k[2] || bus.out_row !== k[1:0] || bus.out_last !== (k == 7)) begin
                errors++;
                $display("FAIL stream_idx%0d got c=%b row=%0d last=%b exp c=%b row=%0d last=%b", k, bus.out_col, bus.out_row, bus.out_last, k[2], k[1:0], (k == 7));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got v=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] hold_r, hold_i;
        logic [2:0]  hold_idx;
        logic        stalled;
        int          n;
        int          cyc;
        stalled  = 1'b0;
        n        = 0;
        cyc      = 0;
        hold_r   = '0;
        hold_i   = '0;
        hold_idx = '0;
        bus.out_ready = 1'b0;
        pulse_set(0);
        while (n < 8 && cyc < 100) begin
            bus.out_ready = pat[cyc % 4];
            if (stalled) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_r !== hold_r || bus.out_i !== hold_i ||
                    {bus.out_col, bus.out_row} !== hold_idx) begin
                    errors++;
                    $display("FAIL bp_hold got v=%b %h,%h idx=%0d exp 1 %h,%h idx=%0d", bus.out_valid, bus.out_r, bus.out_i,
                             {bus.out_col, bus.out_row}, hold_r, hold_i, hold_idx);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                checks++;
                if (bus.out_r !== exp_r[0][n] || bus.out_i !== exp_i[0][n] || bus.out_last !== (n == 7)) begin
                    errors++;
                    $display("FAIL bp_elem%0d got %h,%h last=%b exp %h,%h last=%b", n, bus.out_r, bus.out_i, bus.out_last,
                             exp_r[0][n], exp_i[0][n], (n == 7));
                end
                n++;
            end
            stalled  = (bus.out_valid === 1'b1) && !bus.out_ready;
            hold_r   = bus.out_r;
            hold_i   = bus.out_i;
            hold_idx = {bus.out_col, bus.out_row};
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n != 8 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got n=%0d v=%b exp 8 0", n, bus.out_valid);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_pending();
        bus.out_ready = 1'b0;
        pulse_set(0);
        @(negedge clk);
        @(negedge clk);
        pulse_set(1);
        checks++;
        if (bus.busy !== 1'b1 || bus.overrun !== 1'b0 || bus.out_r !== 16'h0100) begin
            errors++;
            $display("FAIL pend_hold got busy=%b ovr=%b r=%h exp 1 0 0100", bus.busy, bus.overrun, bus.out_r);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_r !== exp_r[k/8][k%8] || bus.out_i !== exp_i[k/8][k%8] ||
                bus.out_last !== (k % 8 == 7)) begin
                errors++;
                $display("FAIL pend_elem%0d got v=%b %h,%h last=%b exp 1 %h,%h last=%b", k, bus.out_valid, bus.out_r, bus.out_i,
                         bus.out_last, exp_r[k/8][k%8], exp_i[k/8][k%8], (k % 8 == 7));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL pend_end got v=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_overrun();
        bus.out_ready = 1'b0;
        pulse_set(0);
        pulse_set(1);
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_early got %b exp 0", bus.overrun);
        end
        pulse_set(2);
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set got %b exp 1", bus.overrun);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_r !== exp_r[k/8][k%8] || bus.out_i !== exp_i[k/8][k%8]) begin
                errors++;
                $display("FAIL ovr_elem%0d got v=%b %h,%h exp 1 %h,%h", k, bus.out_valid, bus.out_r, bus.out_i,
                         exp_r[k/8][k%8], exp_i[k/8][k%8]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_end got v=%b ovr=%b exp 0 1", bus.out_valid, bus.overrun);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.out_ready = 1'b1;
        pulse_set(0);
        repeat (7) @(negedge clk);
        checks++;
        if (bus.out_last !== 1'b1 || bus.out_r !== 16'hFC00) begin
            errors++;
            $display("FAIL sim_last got last=%b r=%h exp 1 FC00", bus.out_last, bus.out_r);
        end
        pulse_set(1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_r !== 16'h1111 || bus.out_i !== 16'h5555 ||
            {bus.out_col, bus.out_row} !== 3'd0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL sim_next got v=%b %h,%h idx=%0d ovr=%b exp 1 1111,5555 idx=0 ovr=0", bus.out_valid, bus.out_r,
                     bus.out_i, {bus.out_col, bus.out_row}, bus.overrun);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL sim_end got v=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        pulse_set(0);
        pulse_set(1);
        pulse_set(2);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_r !== 16'h0400 || bus.overrun !== 1'b1 || bus.out_row !== 2'd3) begin
            errors++;
            $display("FAIL rstmid_pre got r=%h ovr=%b row=%0d exp 0400 1 3", bus.out_r, bus.overrun, bus.out_row);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_post got v=%b busy=%b ovr=%b exp 0 0 0", bus.out_valid, bus.busy, bus.overrun);
        end
        rst = 1'b0;
        pulse_set(1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_r !== exp_r[1][k] || bus.out_i !== exp_i[1][k] ||
                {bus.out_col, bus.out_row} !== k[2:0]) begin
                errors++;
                $display("FAIL rstmid_elem%0d got v=%b %h,%h idx=%0d exp 1 %h,%h idx=%0d", k, bus.out_valid, bus.out_r,
                         bus.out_i, {bus.out_col, bus.out_row}, exp_r[1][k], exp_i[1][k], k);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_end got v=%b exp 0", bus.out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.col_valid = 1'b0;
        bus.col0_r    = '0;
        bus.col0_i    = '0;
        bus.col1_r    = '0;
        bus.col1_i    = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_pending();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
